// File: rtl/vga_text_console.sv
// Character-cell text engine for the 86x32 VGA console: decodes a byte stream into
// screen-RAM writes with wrap and hardware scrolling, and serves the display read port.
module vga_text_console #(
  parameter int          COLS = 86,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        vga_req,
  input  logic [11:0] vga_addr,
  output logic [7:0]  vga_ascii,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic [4:0]  scroll_top
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

  state_t      state, state_nx;
  logic [11:0] clr_cnt, clr_cnt_nx;
  logic [6:0]  line_col, line_col_nx;
  logic [6:0]  col_nx;
  logic [4:0]  row_nx, top_nx;
  logic        do_nl;
  logic        accept;
  logic [4:0]  phys_row;
  logic [6:0]  col_m1;

  logic        we;
  logic [11:0] waddr;
  logic [7:0]  wdata;
  logic [11:0] raddr;
  logic [7:0]  mem [4096];

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign phys_row = cursor_row + scroll_top;
  assign col_m1   = cursor_col - 7'd1;
  assign raddr    = {vga_addr[11:7] + scroll_top, vga_addr[6:0]};

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx    = state;
    clr_cnt_nx  = clr_cnt;
    line_col_nx = line_col;
    col_nx      = cursor_col;
    row_nx      = cursor_row;
    top_nx      = scroll_top;
    do_nl       = 1'b0;
    we          = 1'b0;
    waddr       = {phys_row, cursor_col};
    wdata       = in_data;

    case (state)
      CLR_ALL: begin
        we         = 1'b1;
        waddr      = clr_cnt;
        wdata      = FILL;
        clr_cnt_nx = clr_cnt + 12'd1;
        if (clr_cnt == 12'hFFF) begin
          state_nx = IDLE;
          col_nx   = '0;
          row_nx   = '0;
          top_nx   = '0;
        end
      end
      CLR_LINE: begin
        // Cursor row and the already-advanced scroll_top point at the old top row.
        we          = 1'b1;
        waddr       = {phys_row, line_col};
        wdata       = FILL;
        line_col_nx = line_col + 7'd1;
        if (line_col == LAST_COL) state_nx = IDLE;
      end
      IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20) begin
            we = 1'b1;
            if (cursor_col < LAST_COL) begin
              col_nx = cursor_col + 7'd1;
            end else begin
              col_nx = '0;
              do_nl  = 1'b1;
            end
          end else begin
            case (in_data)
              8'h0D: col_nx = '0;
              8'h0A: do_nl  = 1'b1;
              8'h08: begin
                if (cursor_col != 7'd0) begin
                  col_nx = col_m1;
                  we     = 1'b1;
                  waddr  = {phys_row, col_m1};
                  wdata  = FILL;
                end
              end
              8'h0C: begin
                state_nx   = CLR_ALL;
                clr_cnt_nx = '0;
              end
              default: ;
            endcase
          end
          if (do_nl) begin
            if (cursor_row != 5'd31) begin
              row_nx = cursor_row + 5'd1;
            end else begin
              top_nx      = scroll_top + 5'd1;
              state_nx    = CLR_LINE;
              line_col_nx = '0;
            end
          end
        end
      end
      default: begin
        state_nx   = CLR_ALL;
        clr_cnt_nx = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLR_ALL;
      clr_cnt    <= '0;
      line_col   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      scroll_top <= '0;
      vga_ascii  <= '0;
    end else begin
      state      <= state_nx;
      clr_cnt    <= clr_cnt_nx;
      line_col   <= line_col_nx;
      cursor_col <= col_nx;
      cursor_row <= row_nx;
      scroll_top <= top_nx;
      if (vga_req) vga_ascii <= mem[raddr];
    end
  end

  // NOTE: the screen RAM has no reset; the CLR_ALL sweep after reset initialises it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Directed self-checking bench for vga_text_console: power-up clear, printing, wrap,
// scrolling, control codes and reset during a full-screen clear.
module tb_vga_text_console;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        vga_req = 1'b0;
  logic [11:0] vga_addr = 12'h000;
  logic [7:0]  vga_ascii;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [4:0]  scroll_top;

  int n_checks = 0;
  int n_pass   = 0;
  int stalls   = 0;

  vga_text_console #(.COLS(86), .FILL(8'h20)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_ascii  (vga_ascii),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .scroll_top (scroll_top)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [11:0] lad(input int row, input int col);
    logic [4:0] r;
    logic [6:0] c;
    r = 5'(row);
    c = 7'(col);
    return {r, c};
  endfunction

  // Called at a negedge; presents one byte for one cycle once the engine is ready.
  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    if (!in_ready) stalls++;
    while (!in_ready && w < 10000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 10000) check("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic read(input logic [11:0] a, output logic [7:0] d);
    vga_req  = 1'b1;
    vga_addr = a;
    @(negedge clk);
    vga_req  = 1'b0;
    d        = vga_ascii;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (!in_ready && n < 10000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, bad, r, c;
    logic [7:0] d;

    // Power-up clear with in_valid held high (ignored code on the bus)
    in_valid = 1'b1;
    in_data  = 8'h07;
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(in_ready),   32'd0);
    check("rst_col",    32'(cursor_col), 32'd0);
    check("rst_row",    32'(cursor_row), 32'd0);
    check("rst_top",    32'(scroll_top), 32'd0);
    check("rst_ascii",  32'(vga_ascii),  32'h00);
    rst = 1'b0;
    count_busy(n);
    in_valid = 1'b0;
    check("powerup_busy", n, 4096);
    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 31);
      c = $urandom_range(0, 85);
      read(lad(r, c), d);
      check("powerup_fill", 32'(d), 32'h20);
    end

    // Print and read back
    send(8'h41);
    send(8'h42);
    read(12'h000, d); check("print_A", 32'(d), 32'h41);
    read(12'h001, d); check("print_B", 32'(d), 32'h42);
    check("print_col", 32'(cursor_col), 32'd2);
    check("print_row", 32'(cursor_row), 32'd0);

    // Line wrap from (0,0)
    send(8'h0C);
    count_busy(n);
    check("ff_busy", n, 4096);
    stalls = 0;
    for (int i = 0; i < 86; i++) begin
      send(8'h78);
      if (i == 84) check("wrap_col85", 32'(cursor_col), 32'd85);
    end
    check("wrap_stalls", stalls, 0);
    check("wrap_col", 32'(cursor_col), 32'd0);
    check("wrap_row", 32'(cursor_row), 32'd1);
    read(lad(0, 85), d); check("wrap_last", 32'(d), 32'h78);
    read(lad(1, 0), d);  check("wrap_next", 32'(d), 32'h20);

    // Scroll
    send(8'h0C);
    send(8'h5A);
    send(8'h0D);
    repeat (31) send(8'h0A);
    check("scroll_pre_row", 32'(cursor_row), 32'd31);
    check("scroll_pre_col", 32'(cursor_col), 32'd0);
    send(8'h4D);
    send(8'h0A);
    count_busy(n);
    check("scroll_busy", n, 86);
    check("scroll_top",  32'(scroll_top), 32'd1);
    check("scroll_row",  32'(cursor_row), 32'd31);
    check("scroll_col",  32'(cursor_col), 32'd1);
    bad = 0;
    for (int i = 0; i < 86; i++) begin
      read(lad(31, i), d);
      if (d !== 8'h20) bad++;
    end
    check("scroll_bottom_fill", bad, 0);
    read(lad(30, 0), d); check("scroll_moved_M", 32'(d), 32'h4D);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      read(lad(i, 0), d);
      if (d === 8'h5A) bad++;
    end
    check("scroll_Z_gone", bad, 0);

    // FF, then reset at clear cycle 1000 with a byte presented during reset
    send(8'h0C);
    repeat (1000) @(negedge clk);
    check("ffrst_mid_busy", 32'(in_ready), 32'd0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h52;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    in_valid = 1'b0;
    check("ffrst_busy", n, 4096);
    check("ffrst_top",  32'(scroll_top), 32'd0);
    check("ffrst_col",  32'(cursor_col), 32'd0);
    check("ffrst_row",  32'(cursor_row), 32'd0);
    read(12'h000, d); check("ffrst_no_R", 32'(d), 32'h20);

    // Control codes; first write races a read of the same cell (read-first)
    stalls = 0;
    check("ctl_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h51;
    vga_req  = 1'b1;
    vga_addr = 12'h000;
    @(negedge clk);
    in_valid = 1'b0;
    vga_req  = 1'b0;
    check("read_first", 32'(vga_ascii), 32'h20);
    check("ctl_q_col", 32'(cursor_col), 32'd1);
    read(12'h000, d); check("ctl_q", 32'(d), 32'h51);
    send(8'h08);
    check("ctl_bs_col", 32'(cursor_col), 32'd0);
    read(12'h000, d); check("ctl_bs_erase", 32'(d), 32'h20);
    send(8'h08);
    send(8'h0D);
    send(8'h07);
    check("ctl_stalls", stalls, 0);
    check("ctl_col", 32'(cursor_col), 32'd0);
    check("ctl_row", 32'(cursor_row), 32'd0);
    read(12'h000, d); check("ctl_cell", 32'(d), 32'h20);
    send(8'hC1);
    read(12'h000, d); check("high_char", 32'(d), 32'hC1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
